// File: rtl/mem_stage.sv
// MEM pipeline stage: issues a data-memory handshake for loads/stores,
// aligns load data, and registers the MEM/WB results.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  Rd_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        reg_write_in,
  input  logic [2:0]  funct3_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic [31:0] wb_data_out,
  output logic [4:0]  Rd_out,
  output logic        reg_write_out,
  output logic        misalign_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_next;
  logic [1:0]  off;
  logic        is_byte, is_half, is_unsigned;
  logic        aligned, mem_op, access_valid, misalign, is_store;
  logic [3:0]  wstrb_fmt;
  logic [31:0] wdata_fmt;
  logic [31:0] rdata_q;
  logic [31:0] shifted;
  logic [31:0] load_data;

  // Access size decode; unlisted funct3 encodings fall through to word.
  always_comb begin
    off          = alu_result_in[1:0];
    is_byte      = (funct3_in == 3'b000) || (funct3_in == 3'b100);
    is_half      = (funct3_in == 3'b001) || (funct3_in == 3'b101);
    is_unsigned  = (funct3_in == 3'b100) || (funct3_in == 3'b101);
    aligned      = is_byte || (is_half && !off[0]) ||
                   (!is_byte && !is_half && (off == 2'b00));
    mem_op       = mem_read_in | mem_write_in;
    access_valid = mem_op & aligned;
    misalign     = mem_op & ~aligned;
    is_store     = mem_write_in & ~mem_read_in;
  end

  always_comb begin
    wstrb_fmt = 4'b0000;
    wdata_fmt = store_data_in;
    if (is_byte) begin
      wdata_fmt = {4{store_data_in[7:0]}};
      if (is_store) wstrb_fmt = 4'b0001 << off;
    end else if (is_half) begin
      wdata_fmt = {2{store_data_in[15:0]}};
      if (is_store) wstrb_fmt = 4'b0011 << off;
    end else begin
      if (is_store) wstrb_fmt = 4'b1111;
    end
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (access_valid) begin
          state_next = ACCESS;
          stall      = 1'b1;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (mem_ack) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Bus signals are captured once at request time and held until the ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'b0000;
    end else if (state == IDLE && access_valid) begin
      mem_req   <= 1'b1;
      mem_we    <= is_store;
      mem_addr  <= {alu_result_in[31:2], 2'b00};
      mem_wdata <= wdata_fmt;
      mem_wstrb <= wstrb_fmt;
    end else if (state == ACCESS && mem_ack) begin
      mem_req <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        rdata_q <= 32'd0;
    else if (state == ACCESS && mem_ack) rdata_q <= mem_rdata;
  end

  // An aligned word access always has off == 0, so the shifted word is the raw word.
  always_comb begin
    shifted = rdata_q >> {off, 3'b000};
    if (is_byte)
      load_data = is_unsigned ? {24'd0, shifted[7:0]}
                              : {{24{shifted[7]}}, shifted[7:0]};
    else if (is_half)
      load_data = is_unsigned ? {16'd0, shifted[15:0]}
                              : {{16{shifted[15]}}, shifted[15:0]};
    else
      load_data = shifted;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_data_out   <= 32'd0;
      Rd_out        <= 5'd0;
      reg_write_out <= 1'b0;
      misalign_out  <= 1'b0;
    end else begin
      misalign_out <= (state == IDLE) & misalign;
      if (!stall) begin
        Rd_out        <= Rd_in;
        reg_write_out <= reg_write_in & ~misalign;
        wb_data_out   <= mem_read_in ? load_data : alu_result_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a transaction-level model sets per-cycle
// expectations and one negedge process compares every DUT output.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_result_in, store_data_in, mem_rdata;
  logic [4:0]  Rd_in;
  logic        mem_read_in, mem_write_in, reg_write_in, mem_ack;
  logic [2:0]  funct3_in;
  logic        mem_req, mem_we, stall, reg_write_out, misalign_out;
  logic [31:0] mem_addr, mem_wdata, wb_data_out;
  logic [3:0]  mem_wstrb;
  logic [4:0]  Rd_out;

  int total = 0;
  int bad   = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_we, exp_rw, exp_mis, exp_wb_dc;
  logic [31:0] exp_addr, exp_wdata, exp_wb;
  logic [3:0]  exp_wstrb;
  logic [4:0]  exp_rd;
  int          stall_cycles;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_wstrb;
  logic        last_we;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .Rd_in(Rd_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .reg_write_in(reg_write_in), .funct3_in(funct3_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .wb_data_out(wb_data_out), .Rd_out(Rd_out),
    .reg_write_out(reg_write_out), .misalign_out(misalign_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bytes per access from funct3 (unknown encodings behave as word).
  function automatic int model_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input int off, input logic [2:0] f3);
    int unsigned sh;
    int v;
    sh = word >> (8 * off);
    case (model_size(f3))
      1: begin
        v = int'(sh % 256);
        if (!f3[2] && v >= 128) v = v - 256;
      end
      2: begin
        v = int'(sh % 65536);
        if (!f3[2] && v >= 32768) v = v - 65536;
      end
      default: v = int'(word);
    endcase
    return 32'(v);
  endfunction

  function automatic logic [3:0] model_strobe(input int off, input int size);
    logic [3:0] s = 4'b0000;
    for (int b = 0; b < 4; b++)
      if (b >= off && b < off + size) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] sd, input int size);
    if (size == 1) return (sd % 256) * 32'h0101_0101;
    if (size == 2) return (sd % 65536) * 32'h0001_0001;
    return sd;
  endfunction

  // Single compare process, sampling mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("stall", {31'd0, stall}, {31'd0, exp_stall});
      if (stall === 1'b1) stall_cycles++;
      checkOutput("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
      if (exp_req) begin
        checkOutput("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        checkOutput("mem_addr", mem_addr, exp_addr);
        checkOutput("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_wstrb});
        if (exp_we) checkOutput("mem_wdata", mem_wdata, exp_wdata);
      end
      if (mem_req === 1'b1) begin
        last_addr  = mem_addr;
        last_wdata = mem_wdata;
        last_wstrb = mem_wstrb;
        last_we    = mem_we;
      end
      checkOutput("Rd_out", {27'd0, Rd_out}, {27'd0, exp_rd});
      checkOutput("reg_write_out", {31'd0, reg_write_out}, {31'd0, exp_rw});
      checkOutput("misalign_out", {31'd0, misalign_out}, {31'd0, exp_mis});
      if (!exp_wb_dc) checkOutput("wb_data_out", wb_data_out, exp_wb);
    end
  end

  // Runs one instruction starting just after a rising edge; ack arrives k cycles after mem_req rises.
  task automatic applyStimulus(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [4:0] rd, input logic rw, input int k,
                               input logic [31:0] word, input logic junk_ack);
    int size, off;
    logic mem, aln, valid;
    logic [31:0] nw_wb;
    size  = model_size(f3);
    off   = int'(addr % 4);
    mem   = rd_en | wr_en;
    aln   = ((addr % size) == 0);
    valid = mem & aln;
    nw_wb = rd_en ? model_load(word, off, f3) : addr;

    mem_read_in = rd_en; mem_write_in = wr_en; funct3_in = f3;
    alu_result_in = addr; store_data_in = sdata; Rd_in = rd; reg_write_in = rw;
    mem_ack = junk_ack; mem_rdata = 32'hDEAD_BEEF;
    stall_cycles = 0;
    exp_stall = valid; exp_req = 1'b0;

    if (valid) begin
      @(posedge clk); #1;
      exp_req   = 1'b1;
      exp_we    = wr_en & ~rd_en;
      exp_addr  = (addr / 4) * 4;
      exp_wstrb = exp_we ? model_strobe(off, size) : 4'b0000;
      exp_wdata = model_wdata(sdata, size);
      exp_mis   = 1'b0;
      for (int i = 0; i <= k; i++) begin
        if (i > 0) begin @(posedge clk); #1; end
        mem_ack   = (i == k);
        mem_rdata = (i == k) ? word : 32'hDEAD_BEEF;
      end
      @(posedge clk); #1;
      exp_stall = 1'b0; exp_req = 1'b0;
      mem_ack = junk_ack; mem_rdata = 32'h5A5A_5A5A;
    end
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    exp_rd    = rd;
    exp_rw    = rw & ~(mem & ~aln);
    exp_mis   = mem & ~aln;
    exp_wb    = nw_wb;
    exp_wb_dc = rd_en & ~aln;
    checkOutput("stall_cycles", stall_cycles, valid ? k + 2 : 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    mem_read_in = 0; mem_write_in = 0; reg_write_in = 0; funct3_in = 3'b010;
    alu_result_in = 0; store_data_in = 0; Rd_in = 0; mem_ack = 0; mem_rdata = 0;
    exp_stall = 0; exp_req = 0; exp_we = 0; exp_rw = 0; exp_mis = 0; exp_wb_dc = 0;
    exp_addr = 0; exp_wdata = 0; exp_wb = 0; exp_wstrb = 0; exp_rd = 0;
    last_addr = 0; last_wdata = 0; last_wstrb = 0; last_we = 0;
    #12;
    checkOutput("reset_req", {31'd0, mem_req}, 32'd0);
    checkOutput("reset_wb", wb_data_out, 32'd0);
    checkOutput("reset_rw", {31'd0, reg_write_out}, 32'd0);
    checkOutput("reset_mis", {31'd0, misalign_out}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1; chk_en = 1'b1;

    // ALU passthrough
    applyStimulus(0, 0, 3'b010, 32'h0000_1234, 0, 5'd5, 1, 0, 0, 0);
    checkOutput("alu_wb", wb_data_out, 32'h0000_1234);
    checkOutput("alu_rd", {27'd0, Rd_out}, 32'd5);
    checkOutput("alu_stalls", stall_cycles, 0);
    // LB 0x103, ack two cycles after request
    applyStimulus(1, 0, 3'b000, 32'h0000_0103, 0, 5'd7, 1, 2, 32'h80FF_0000, 0);
    checkOutput("lb_wb", wb_data_out, 32'hFFFF_FF80);
    checkOutput("lb_addr", last_addr, 32'h0000_0100);
    checkOutput("lb_stalls", stall_cycles, 4);
    // SH 0x202, immediate ack
    applyStimulus(0, 1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 5'd8, 0, 0, 0, 0);
    checkOutput("sh_wstrb", {28'd0, last_wstrb}, 32'hC);
    checkOutput("sh_wdata", last_wdata, 32'hABCD_ABCD);
    checkOutput("sh_we", {31'd0, last_we}, 32'd1);
    checkOutput("sh_stalls", stall_cycles, 2);
    checkOutput("sh_rw", {31'd0, reg_write_out}, 32'd0);
    // Misaligned LW
    applyStimulus(1, 0, 3'b010, 32'h0000_0301, 0, 5'd9, 1, 0, 0, 0);
    checkOutput("lw_mis", {31'd0, misalign_out}, 32'd1);
    checkOutput("lw_mis_rw", {31'd0, reg_write_out}, 32'd0);
    // LHU / LH with spurious acks in IDLE and DONE
    applyStimulus(1, 0, 3'b101, 32'h0000_0402, 0, 5'd10, 1, 1, 32'h8001_7FFF, 0);
    checkOutput("lhu_wb", wb_data_out, 32'h0000_8001);
    applyStimulus(1, 0, 3'b001, 32'h0000_0402, 0, 5'd11, 1, 1, 32'h8001_7FFF, 1);
    checkOutput("lh_wb", wb_data_out, 32'hFFFF_8001);
    // More store/load shapes
    applyStimulus(0, 1, 3'b000, 32'h0000_0005, 32'h1234_5678, 5'd12, 1, 1, 0, 0);
    checkOutput("sb_wstrb", {28'd0, last_wstrb}, 32'h2);
    checkOutput("sb_wdata", last_wdata, 32'h7878_7878);
    applyStimulus(0, 1, 3'b010, 32'h0000_0008, 32'hCAFE_BABE, 5'd13, 1, 0, 0, 0);
    checkOutput("sw_wstrb", {28'd0, last_wstrb}, 32'hF);
    applyStimulus(1, 0, 3'b100, 32'h0000_0006, 0, 5'd14, 1, 3, 32'h11AA_2233, 0);
    checkOutput("lbu_wb", wb_data_out, 32'h0000_00AA);
    applyStimulus(1, 0, 3'b011, 32'h0000_000C, 0, 5'd15, 1, 0, 32'h8765_4321, 0);
    checkOutput("f3_011_wb", wb_data_out, 32'h8765_4321);
    applyStimulus(1, 0, 3'b110, 32'h0000_000E, 0, 5'd16, 1, 0, 0, 0);
    applyStimulus(1, 1, 3'b010, 32'h0000_0010, 32'hFFFF_FFFF, 5'd17, 1, 1, 32'h0BAD_F00D, 0);
    checkOutput("rw_both_we", {31'd0, last_we}, 32'd0);
    checkOutput("rw_both_wstrb", {28'd0, last_wstrb}, 32'd0);
    applyStimulus(0, 1, 3'b001, 32'h0000_0011, 32'h0000_7777, 5'd18, 1, 0, 0, 0);
    applyStimulus(0, 0, 3'b010, 32'h0000_A5A5, 0, 5'd3, 1, 0, 0, 0);

    // Reset while a load is waiting for its ack
    chk_en = 1'b0;
    mem_read_in = 1; mem_write_in = 0; funct3_in = 3'b010;
    alu_result_in = 32'h0000_0020; Rd_in = 5'd9; reg_write_in = 1; mem_ack = 0;
    @(posedge clk); #1;
    checkOutput("rst_pre_req", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #3;
    reset = 1'b1; #1;
    checkOutput("rst_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_addr", mem_addr, 32'd0);
    checkOutput("rst_wb", wb_data_out, 32'd0);
    checkOutput("rst_rd", {27'd0, Rd_out}, 32'd0);
    checkOutput("rst_rw", {31'd0, reg_write_out}, 32'd0);
    mem_read_in = 0; alu_result_in = 0; Rd_in = 0; reg_write_in = 0; #1;
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    mem_ack = 1;
    @(posedge clk); #1; mem_ack = 0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1; mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1; mem_ack = 0;
    checkOutput("post_rst_req", {31'd0, mem_req}, 32'd0);
    checkOutput("post_rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("post_rst_wb", wb_data_out, 32'd0);
    exp_stall = 0; exp_req = 0; exp_rw = 0; exp_mis = 0; exp_wb_dc = 0;
    exp_wb = 0; exp_rd = 0;
    chk_en = 1'b1;
    applyStimulus(0, 0, 3'b010, 32'h0000_0042, 0, 5'd1, 1, 0, 0, 0);
    applyStimulus(1, 0, 3'b010, 32'h0000_0040, 0, 5'd2, 1, 1, 32'h1357_9BDF, 0);
    checkOutput("post_rst_lw", wb_data_out, 32'h1357_9BDF);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
